// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: pattern type, blank pattern and glyphs.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package seg_pkg;

    // Active-high segment pattern, bit6 = a ... bit0 = g.
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b0000000;

    // Digits 0-9
    localparam seg_t SEG_0 = 7'b1111110;
    localparam seg_t SEG_1 = 7'b0110000;
    localparam seg_t SEG_2 = 7'b1101101;
    localparam seg_t SEG_3 = 7'b1111001;
    localparam seg_t SEG_4 = 7'b0110011;
    localparam seg_t SEG_5 = 7'b1011011;
    localparam seg_t SEG_6 = 7'b1011111;
    localparam seg_t SEG_7 = 7'b1110000;
    localparam seg_t SEG_8 = 7'b1111111;
    localparam seg_t SEG_9 = 7'b1111011;

    // Letters used by the ATM front panel
    localparam seg_t SEG_A    = 7'b1110111;
    localparam seg_t SEG_C    = 7'b1001110;
    localparam seg_t SEG_d    = 7'b0111101;
    localparam seg_t SEG_E    = 7'b1001111;
    localparam seg_t SEG_L    = 7'b0001110;
    localparam seg_t SEG_n    = 7'b0010101;
    localparam seg_t SEG_o    = 7'b0011101;
    localparam seg_t SEG_P    = 7'b1100111;
    localparam seg_t SEG_r    = 7'b0000101;
    localparam seg_t SEG_DASH = 7'b0000001;

endpackage

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment driver with per-slot blanking, blink and frame strobe.
// Latency: outputs registered, reflecting counter state after each clk edge (no extra pipeline).
// Backpressure: none; free-running scan, enable only gates the anodes.
//
// Ports: clk/rst (async active-high), digit1..digit4 active-high patterns,
// blink[3:0] per-digit blink, enable; a..g cathodes and an0..an3 anodes
// (both active-low), frame_tick one-cycle pulse at each frame wrap.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYC    = 500,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  seg_t       digit1,
    input  seg_t       digit2,
    input  seg_t       digit3,
    input  seg_t       digit4,
    input  logic [3:0] blink,
    input  logic       enable,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       e,
    output logic       f,
    output logic       g,
    output logic       an0,
    output logic       an1,
    output logic       an2,
    output logic       an3,
    output logic       frame_tick
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CW-1:0] CNT_MAX   = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);
    localparam logic [CW-1:0] CNT_CAP   = CW'(BLANK_CYC - 1);
    localparam logic [FW-1:0] FCNT_MAX  = FW'(BLINK_FRAMES - 1);

    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    idx, idx_nxt;
    logic [FW-1:0] fcnt, fcnt_nxt;
    logic          bphase, bphase_nxt;
    seg_t          pat, pat_nxt, digit_sel;

    logic          slot_wrap, frame_wrap, blink_wrap;
    logic          drive_nxt, show_nxt;
    logic [3:0]    an_nxt, an_q;
    seg_t          cath_nxt, cath_q;
    logic          ft_q;

    // Everything is computed from the post-edge counter values so the
    // registered outputs line up with the counters without a cycle of lag.
    always_comb begin
        slot_wrap  = (cnt == CNT_MAX);
        frame_wrap = slot_wrap && (idx == 2'd3);
        blink_wrap = frame_wrap && (fcnt == FCNT_MAX);

        cnt_nxt    = slot_wrap ? '0 : cnt + 1'b1;
        idx_nxt    = slot_wrap ? idx + 2'd1 : idx;
        fcnt_nxt   = fcnt;
        if (frame_wrap)
            fcnt_nxt = (fcnt == FCNT_MAX) ? '0 : fcnt + 1'b1;
        bphase_nxt = bphase ^ blink_wrap;

        case (idx)
            2'd0:    digit_sel = digit1;
            2'd1:    digit_sel = digit2;
            2'd2:    digit_sel = digit3;
            default: digit_sel = digit4;
        endcase

        // Capture on the BLANK->DRIVE transition only, so the pattern shown
        // for a slot never tears when inputs change mid-slot. idx cannot
        // change on this edge because BLANK_CYC <= SCAN_DIV-2.
        pat_nxt   = (cnt == CNT_CAP) ? digit_sel : pat;

        drive_nxt = (cnt_nxt >= CNT_BLANK);
        show_nxt  = drive_nxt && enable && !(blink[idx_nxt] && bphase_nxt);

        // One-hot-low by construction: at most one anode can be driven.
        an_nxt = 4'b1111;
        if (show_nxt)
            an_nxt[idx_nxt] = 1'b0;

        // Cathodes follow the pattern even when the anode is suppressed;
        // only the BLANK phase forces them off.
        cath_nxt = drive_nxt ? ~pat_nxt : 7'h7f;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            idx    <= '0;
            fcnt   <= '0;
            bphase <= 1'b0;
            pat    <= SEG_BLANK;
            an_q   <= 4'b1111;
            cath_q <= 7'h7f;
            ft_q   <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            idx    <= idx_nxt;
            fcnt   <= fcnt_nxt;
            bphase <= bphase_nxt;
            pat    <= pat_nxt;
            an_q   <= an_nxt;
            cath_q <= cath_nxt;
            ft_q   <= frame_wrap;
        end
    end

    assign {a, b, c, d, e, f, g}  = cath_q;
    assign {an3, an2, an1, an0}   = an_q;
    assign frame_tick             = ft_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver with SCAN_DIV=8, BLANK_CYC=2, BLINK_FRAMES=2.
// Expected (edge, anodes, cathodes, frame_tick) entries are queued by the
// stimulus and compared by a negedge monitor once that edge has occurred.
module tb_seg_scan_driver;

    logic       clk;
    logic       rst;
    logic [6:0] digit1, digit2, digit3, digit4;
    logic [3:0] blink;
    logic       enable;
    logic       a, b, c, d, e, f, g;
    logic       an0, an1, an2, an3;
    logic       frame_tick;

    seg_scan_driver #(
        .SCAN_DIV    (8),
        .BLANK_CYC   (2),
        .BLINK_FRAMES(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .digit1    (digit1),
        .digit2    (digit2),
        .digit3    (digit3),
        .digit4    (digit4),
        .blink     (blink),
        .enable    (enable),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .e         (e),
        .f         (f),
        .g         (g),
        .an0       (an0),
        .an1       (an1),
        .an2       (an2),
        .an3       (an3),
        .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         edge_n;
        logic [3:0] an;
        logic [6:0] cath;
        logic       ft;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   k;  // rising edges since reset release

    // Hand-computed cathode values (inverted patterns)
    localparam logic [6:0] OFF7 = 7'b1111111;
    localparam logic [3:0] OFF4 = 4'b1111;
    localparam logic [6:0] C_D1  = 7'b0000001;  // ~1111110
    localparam logic [6:0] C_D2  = 7'b1001111;  // ~0110000
    localparam logic [6:0] C_D3  = 7'b0010010;  // ~1101101
    localparam logic [6:0] C_D4  = 7'b0000110;  // ~1111001
    localparam logic [6:0] C_D1N = 7'b1001100;  // ~0110011

    always @(posedge clk or posedge rst) begin
        if (rst) k <= 0;
        else     k <= k + 1;
    end

    task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp_v);
        end
    endtask

    task automatic push(input int en, input logic [3:0] an_e, input logic [6:0] cath_e, input logic ft_e);
        exp_t x;
        x.edge_n = en;
        x.an     = an_e;
        x.cath   = cath_e;
        x.ft     = ft_e;
        q.push_back(x);
    endtask

    task automatic push_range(input int lo, input int hi, input logic [3:0] an_e, input logic [6:0] cath_e);
        for (int i = lo; i <= hi; i++)
            push(i, an_e, cath_e, 1'b0);
    endtask

    // Return after edge n has occurred (1 time unit past the edge).
    task automatic wait_edge(input int n);
        int guard;
        guard = 0;
        while (k < n && guard < 1000) begin
            @(posedge clk);
            #1;
            guard++;
        end
    endtask

    task automatic release_rst();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drain(input string nm);
        repeat (3) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_%s: got %0d pending expected 0", nm, q.size());
            q.delete();
        end
    endtask

    // Monitor: compare every queued expectation whose edge has been reached.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (!rst) begin
                while (q.size() > 0 && q[0].edge_n <= k) begin
                    x = q.pop_front();
                    if (x.edge_n < k) begin
                        checks++;
                        errors++;
                        $display("FAIL missed@%0d: got edge %0d expected edge %0d", x.edge_n, k, x.edge_n);
                    end else begin
                        chk($sformatf("an@%0d", x.edge_n), {3'b000, an3, an2, an1, an0}, {3'b000, x.an});
                        chk($sformatf("cath@%0d", x.edge_n), {a, b, c, d, e, f, g}, x.cath);
                        chk($sformatf("ft@%0d", x.edge_n), {6'd0, frame_tick}, {6'd0, x.ft});
                    end
                end
            end
        end
    end

    initial begin
        rst    = 1'b1;
        digit1 = 7'b1111110;
        digit2 = 7'b0110000;
        digit3 = 7'b1101101;
        digit4 = 7'b1111001;
        blink  = 4'b0000;
        enable = 1'b1;

        // Reset held
        repeat (3) @(posedge clk);
        #2;
        chk("rst_an", {3'b000, an3, an2, an1, an0}, {3'b000, OFF4});
        chk("rst_cath", {a, b, c, d, e, f, g}, OFF7);
        chk("rst_ft", {6'd0, frame_tick}, 7'd0);

        // Basic scan, tear-free capture, frame ticks
        push_range(0, 1, OFF4, OFF7);
        push_range(2, 7, 4'b1110, C_D1);
        push_range(8, 9, OFF4, OFF7);
        push_range(10, 15, 4'b1101, C_D2);
        push_range(18, 23, 4'b1011, C_D3);
        push_range(26, 31, 4'b0111, C_D4);
        push(32, OFF4, OFF7, 1'b1);
        push(33, OFF4, OFF7, 1'b0);
        push_range(34, 39, 4'b1110, C_D1N);
        push(64, OFF4, OFF7, 1'b1);
        push(65, OFF4, OFF7, 1'b0);
        push(96, OFF4, OFF7, 1'b1);
        push(97, OFF4, OFF7, 1'b0);
        release_rst();
        wait_edge(3);
        digit1 = 7'b0110011;  // sampled from edge 4 on
        wait_edge(97);
        drain("basic");

        // Blink on digit1
        rst    = 1'b1;
        digit1 = 7'b1111110;
        blink  = 4'b0001;
        push_range(2, 7, 4'b1110, C_D1);
        push_range(34, 39, 4'b1110, C_D1);
        push_range(66, 71, OFF4, C_D1);
        push_range(74, 79, 4'b1101, C_D2);
        push_range(98, 103, OFF4, C_D1);
        push_range(106, 111, 4'b1101, C_D2);
        push_range(130, 135, 4'b1110, C_D1);
        release_rst();
        wait_edge(135);
        drain("blink");

        // Enable gating
        rst   = 1'b1;
        blink = 4'b0000;
        push_range(2, 3, 4'b1110, C_D1);
        push_range(4, 7, OFF4, C_D1);
        push_range(10, 11, OFF4, C_D2);
        push_range(12, 15, 4'b1101, C_D2);
        push(32, OFF4, OFF7, 1'b1);
        release_rst();
        wait_edge(3);
        enable = 1'b0;
        wait_edge(11);
        enable = 1'b1;
        wait_edge(32);
        drain("enable");

        // Asynchronous reset mid-DRIVE, then restart at slot 0
        rst = 1'b1;
        release_rst();
        wait_edge(4);
        chk("pre_rst_an", {3'b000, an3, an2, an1, an0}, 7'b0001110);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_an", {3'b000, an3, an2, an1, an0}, {3'b000, OFF4});
        chk("mid_rst_cath", {a, b, c, d, e, f, g}, OFF7);
        chk("mid_rst_ft", {6'd0, frame_tick}, 7'd0);
        push_range(0, 1, OFF4, OFF7);
        push_range(2, 4, 4'b1110, C_D1);
        release_rst();
        wait_edge(4);
        drain("restart");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed seven-segment scan driver, downstream of the ATM controller. It takes four 7-bit active-high segment patterns and drives the shared active-low cathodes `a`..`g` and active-low anodes `an0`..`an3`. It adds per-slot anti-ghost blanking, tear-free pattern capture, per-digit blink and a frame strobe. It runs on the undivided board clock.

## Interface
- `SCAN_DIV`, 50000: clk cycles per digit slot; must be ≥ `BLANK_CYC`+2.
- `BLANK_CYC`, 500: cycles at the start of each slot with all anodes off; must be ≥ 1.
- `BLINK_FRAMES`, 64: frames per blink half-period; must be ≥ 1.
- `clk` in 1: board clock; the only clock.
- `rst` in 1: reset, asynchronous and active-high.
- `digit1`..`digit4` in 7 each: segment pattern, active-high; bit6 = a … bit0 = g. `digit1` maps to `an0`, `digit4` to `an3`.
- `blink` in 4: bit i set makes digit i+1 blink.
- `enable` in 1: 0 forces all anodes off; the counters keep running.
- `a`..`g` out 1 each: cathodes, active-low.
- `an0`..`an3` out 1 each: anodes, active-low.
- `frame_tick` out 1: one-cycle pulse at the end of every 4-slot frame.

## Operation
- Counters:
  - `cnt`: 0..`SCAN_DIV`-1, increments every clk and wraps.
  - `idx`: 0..3, advances when `cnt` wraps; wraps 3→0.
  - `fcnt`: 0..`BLINK_FRAMES`-1, advances when `idx` wraps.
  - `bphase`: toggles when `fcnt` wraps.
  - All counter widths use `$clog2`.
- Per-slot phases, derived from `cnt`:
  - BLANK (`cnt` < `BLANK_CYC`): all anodes 1, all cathodes 1.
  - DRIVE (`cnt` ≥ `BLANK_CYC`): anode `idx` is 0 unless suppressed; cathodes = ~pattern.
- Pattern capture: `digit[idx]` is latched into the pattern register on the edge where `cnt` goes `BLANK_CYC`-1 → `BLANK_CYC`. Input changes during DRIVE are ignored until that digit's next slot.
- Suppression: anode `idx` stays 1 for the slot if `enable`=0, or if `blink[idx]`=1 and `bphase`=1. Cathodes still follow the pattern; with the anode off they are not visible.
- `frame_tick` = 1 for exactly the cycle following the edge where `idx` wraps 3→0.
- Reset values (asynchronous, immediate):
  - `a`..`g` = 1; `an0`..`an3` = 1; `frame_tick` = 0.
  - `cnt` = 0, `idx` = 0, `fcnt` = 0, `bphase` = 0 (visible).
  - Pattern register = 0.
- Reset mid-slot: all outputs go inactive at once, and scanning restarts at slot 0 BLANK on release.
- At most one anode is low at any time, in every cycle including reset.

## Timing
- All outputs are registered and reflect the counter state after each edge; there is no extra pipeline latency.
- Edge k is the k-th rising clk edge after `rst` deasserts. After edge k, `cnt` = k mod `SCAN_DIV`.
- Anode i is low after edges `i*SCAN_DIV+BLANK_CYC` through `(i+1)*SCAN_DIV-1` of each frame. It is high again after edge `(i+1)*SCAN_DIV`, which is also the new slot's first BLANK cycle.
- Frame length is 4·`SCAN_DIV` cycles. `frame_tick` is high after edge `4n·SCAN_DIV` for n ≥ 1, and low after the next edge.
- Blink period is 2·`BLINK_FRAMES` frames with a 50 % duty cycle, visible half first.
- `enable` is sampled every edge; a change takes effect after the same edge.

## Structure
- Shared package `seg_pkg`:
  - `SEG_BLANK` = 7'b0000000.
  - Glyph constants for 0–9 and the ATM letters (e.g. `SEG_E`, `SEG_r`, `SEG_P`), active-high in a..g bit order.
  - Type `seg_t` = logic [6:0].
- Single module with no sub-modules; the three counters and the phase decode fit comfortably in one block.

## Test plan
All scenarios use `SCAN_DIV`=8, `BLANK_CYC`=2, `BLINK_FRAMES`=2.
- Reset held: all cathodes and anodes = 1, `frame_tick` = 0. Assert `rst` mid-DRIVE → same values immediately, without waiting for a clk edge.
- `digit1`=7'b1111110, `digit2`=7'b0110000, `enable`=1, `blink`=0:
  - `an0` = 0 after edges 2..7, with `a`..`f`=0 and `g`=1.
  - `an1` = 0 after edges 10..15, with `a`=1, `b`=0, `c`=0, `d`..`g`=1.
  - All anodes = 1 after edges 0, 1, 8, 9.
- Change `digit1` at edge 4 → `an0` slot keeps the old pattern through edge 7. New pattern appears after edge 34.
- `frame_tick` = 1 only after edges 32, 64 and 96; it is 0 after edges 33 and 65.
- `blink`=4'b0001 → `an0` active in frames 0–1 (edges 2–7, 34–39); stays 1 in frames 2–3 (edges 66–71, 98–103); active again from edge 130. `an1`–`an3` are unaffected.
- `enable`=0 at edge 4 → `an0`=1 from edge 4 onward. `enable`=1 at edge 12 → `an1`=0 after edge 12. `frame_tick` still fires at edge 32.
